// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // One bit time at 9600 baud from a 12 MHz clock.
  localparam int CLKS_PER_BIT = 1250;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rtl/uart_tx_arbiter_rr_select.sv - combinational round-robin pick:
// first asserted request at or after ptr, wrapping modulo N
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = IDX_W'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-granular round-robin sharing of one UART
// transmitter byte port, with an idle gap between frames
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BYTES  = 64,
  parameter int GAP_CYCLES = CLKS_PER_BIT,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clock_12MHz,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_idx;
  logic            sel_found;
  logic [ID_W-1:0] next_ptr;
  logic [7:0]      byte_cnt;
  logic [15:0]     gap_cnt;
  logic            reg_open;
  logic            take;
  byte_t           cur_byte;
  logic            cur_valid;
  logic            cur_last;

  rr_select #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_select (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign reg_open = !tx_valid || tx_ready;
  assign busy     = (state != IDLE);
  assign next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  // Mux out the granted requester's lane; ready only ever reaches that lane.
  always_comb begin
    cur_byte  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        cur_byte  = req_data[8*i +: 8];
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        if (state == SEND && !reset) begin
          req_ready[i] = reg_open;
        end
      end
    end
  end

  assign take = (state == SEND) && cur_valid && reg_open;

  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            grant_id <= sel_idx;
            byte_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (take) begin
            tx_data  <= cur_byte;
            tx_valid <= 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
            // A byte cap release and a real frame end look the same here.
            if (cur_last || byte_cnt == 8'(MAX_BYTES - 1)) begin
              state <= DRAIN;
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (reg_open) begin
            tx_valid <= 1'b0;
            rr_ptr   <= next_ptr;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= 16'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          tx_valid <= 1'b0;
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - two arbiter instances (default and MAX_BYTES=4,
// GAP_CYCLES=0) checked every cycle against a frame-level reference model
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic clock_12MHz = 1'b0;
  always #5 clock_12MHz = ~clock_12MHz;

  logic             rst [2];
  logic [NR-1:0]    rv  [2];
  logic [NR-1:0]    rl  [2];
  logic [NR-1:0]    rr  [2];
  logic [8*NR-1:0]  rd  [2];
  logic [7:0]       txd [2];
  logic             txv [2];
  logic             txr [2];
  logic             bsy [2];
  logic [1:0]       gid [2];

  uart_tx_arbiter #(.NUM_REQ(NR)) dut0 (
    .clock_12MHz (clock_12MHz), .reset (rst[0]),
    .req_valid (rv[0]), .req_data (rd[0]), .req_last (rl[0]), .req_ready (rr[0]),
    .tx_data (txd[0]), .tx_valid (txv[0]), .tx_ready (txr[0]),
    .grant_id (gid[0]), .busy (bsy[0])
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BYTES(4), .GAP_CYCLES(0)) dut1 (
    .clock_12MHz (clock_12MHz), .reset (rst[1]),
    .req_valid (rv[1]), .req_data (rd[1]), .req_last (rl[1]), .req_ready (rr[1]),
    .tx_data (txd[1]), .tx_valid (txv[1]), .tx_ready (txr[1]),
    .grant_id (gid[1]), .busy (bsy[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // requester queues: bits [7:0] data, bit 8 last
  int   rq [2][NR][$];
  int   vprob [2];
  int   rprob [2];
  int   rpat  [2][$];
  logic rst_next [2];

  // reference model, one per lane
  int m_owner [2];
  int m_sent  [2];
  int m_gap   [2];
  int m_ptr   [2];
  int m_gid   [2];
  bit m_closing [2];
  int m_out [2][$];

  // observed transmit log and sampled snapshots
  int lg_d [2][$];
  int lg_g [2][$];
  int lg_c [2][$];
  int gchg [2];
  int prev_g [2];
  int ib [2];
  int s_txv [2], s_txd [2], s_gid [2], s_bsy [2], s_rr [2];

  function automatic int maxb(int l);
    return (l == 0) ? 64 : 4;
  endfunction

  function automatic int gapc(int l);
    return (l == 0) ? 1250 : 0;
  endfunction

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit m_ready(int l, int i);
    return !rst[l] && m_owner[l] == i && !m_closing[l] &&
           (m_out[l].size() == 0 || txr[l]);
  endfunction

  function automatic bit lane_idle(int l);
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq[l][i].size() != 0) e = 1'b0;
    return e && m_owner[l] < 0 && m_gap[l] == 0 && m_out[l].size() == 0;
  endfunction

  task automatic drive(int l);
    int h;
    int t;
    rst[l] = rst_next[l];
    if (rpat[l].size() > 0) begin
      t = rpat[l].pop_front();
      txr[l] = (t != 0);
    end else begin
      txr[l] = ($urandom_range(99) < rprob[l]);
    end
    for (int i = 0; i < NR; i++) begin
      if (rq[l][i].size() > 0 && $urandom_range(99) < vprob[l]) begin
        h = rq[l][i][0];
        rv[l][i] = 1'b1;
        rd[l][8*i +: 8] = h[7:0];
        rl[l][i] = h[8];
      end else begin
        rv[l][i] = 1'b0;
        rd[l][8*i +: 8] = 8'h00;
        rl[l][i] = 1'b0;
      end
    end
  endtask

  task automatic compare(int l);
    logic [NR-1:0] er;
    for (int i = 0; i < NR; i++) er[i] = m_ready(l, i);
    chk($sformatf("L%0d busy", l), bsy[l], (m_owner[l] >= 0 || m_gap[l] > 0) ? 1 : 0);
    chk($sformatf("L%0d tx_valid", l), txv[l], (m_out[l].size() > 0) ? 1 : 0);
    if (m_out[l].size() > 0) chk($sformatf("L%0d tx_data", l), txd[l], m_out[l][0]);
    chk($sformatf("L%0d grant_id", l), gid[l], m_gid[l]);
    chk($sformatf("L%0d req_ready", l), rr[l], er);
    s_txv[l] = txv[l]; s_txd[l] = txd[l]; s_gid[l] = gid[l];
    s_bsy[l] = bsy[l]; s_rr[l] = rr[l];
    if (bsy[l] && !txv[l]) ib[l]++;
    if (gid[l] != prev_g[l]) begin
      gchg[l] = cyc;
      prev_g[l] = gid[l];
    end
    if (!rst[l] && txv[l] && txr[l]) begin
      lg_d[l].push_back(txd[l]);
      lg_g[l].push_back(gid[l]);
      lg_c[l].push_back(cyc);
    end
  endtask

  task automatic step(int l);
    bit fire;
    bit rdy;
    bit got;
    int c;
    int h;
    if (rst[l]) begin
      m_owner[l] = -1; m_sent[l] = 0; m_gap[l] = 0; m_ptr[l] = 0;
      m_gid[l] = 0; m_closing[l] = 1'b0; m_out[l].delete();
      return;
    end
    fire = m_out[l].size() > 0 && txr[l];
    if (m_owner[l] < 0 && m_gap[l] == 0) begin
      got = 1'b0;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr[l] + k) % NR;
        if (!got && rv[l][c]) begin
          got = 1'b1;
          m_owner[l] = c; m_sent[l] = 0; m_gid[l] = c;
        end
      end
    end else if (m_gap[l] > 0) begin
      m_gap[l]--;
    end else if (!m_closing[l]) begin
      rdy = m_ready(l, m_owner[l]);
      if (fire) m_out[l].delete();
      if (rdy && rv[l][m_owner[l]]) begin
        h = rq[l][m_owner[l]].pop_front();
        m_out[l].push_back(h & 255);
        m_sent[l]++;
        if (h[8] || m_sent[l] == maxb(l)) m_closing[l] = 1'b1;
      end
    end else if (m_out[l].size() == 0 || txr[l]) begin
      m_out[l].delete();
      m_ptr[l] = (m_owner[l] + 1) % NR;
      m_owner[l] = -1;
      m_closing[l] = 1'b0;
      m_gap[l] = gapc(l);
    end
  endtask

  task automatic cycle();
    @(negedge clock_12MHz);
    drive(0);
    drive(1);
    #1;
    cyc++;
    compare(0);
    compare(1);
    @(posedge clock_12MHz);
    step(0);
    step(1);
  endtask

  task automatic run_until_idle(int l, int maxc);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!lane_idle(l) && n < maxc);
    chk($sformatf("L%0d completes within %0d cycles", l, maxc), lane_idle(l), 1);
  endtask

  task automatic push_frame(int l, int i, int base, int n);
    for (int k = 0; k < n; k++)
      rq[l][i].push_back(((base + k) & 255) | ((k == n - 1) ? 256 : 0));
  endtask

  task automatic clr_log(int l);
    lg_d[l].delete(); lg_g[l].delete(); lg_c[l].delete();
  endtask

  task automatic chk_log(int l, string nm, input int ed[$], input int eg[$]);
    chk({nm, " count"}, lg_d[l].size(), ed.size());
    for (int k = 0; k < ed.size() && k < lg_d[l].size(); k++) begin
      chk($sformatf("%s byte%0d", nm, k), lg_d[l][k], ed[k]);
      chk($sformatf("%s gid%0d", nm, k), lg_g[l][k], eg[k]);
    end
  endtask

  initial begin
    int ed[$];
    int eg[$];
    int c0;
    int n;
    int pushed [2];
    int len;

    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; rst_next[l] = 1'b1;
      rv[l] = '0; rl[l] = '0; rd[l] = '0; txr[l] = 1'b0;
      vprob[l] = 100; rprob[l] = 100;
      m_owner[l] = -1; m_sent[l] = 0; m_gap[l] = 0; m_ptr[l] = 0;
      m_gid[l] = 0; m_closing[l] = 1'b0;
      gchg[l] = -1; prev_g[l] = 0; ib[l] = 0; pushed[l] = 0;
    end

    repeat (3) cycle();
    chk("reset tx_valid", s_txv[0], 0);
    chk("reset tx_data", s_txd[0], 0);
    chk("reset grant_id", s_gid[0], 0);
    chk("reset busy", s_bsy[0], 0);
    chk("reset req_ready", s_rr[0], 0);
    rst_next[0] = 1'b0;
    rst_next[1] = 1'b0;
    cycle();

    // single frame, default gap
    clr_log(0); ib[0] = 0;
    push_frame(0, 0, 'h41, 3);
    c0 = cyc + 1;
    run_until_idle(0, 2000);
    ed = '{'h41, 'h42, 'h43}; eg = '{0, 0, 0};
    chk_log(0, "single", ed, eg);
    if (lg_c[0].size() > 0) chk("first byte latency", lg_c[0][0] - c0, 2);
    chk("busy idle cycles incl gap", ib[0], 1251);

    // round robin with wrap of the pointer
    clr_log(0);
    push_frame(0, 1, 'h11, 2);
    push_frame(0, 2, 'h21, 2);
    run_until_idle(0, 4000);
    push_frame(0, 0, 'h01, 2);
    push_frame(0, 1, 'h13, 2);
    run_until_idle(0, 4000);
    ed = '{'h11, 'h12, 'h21, 'h22, 'h01, 'h02, 'h13, 'h14};
    eg = '{1, 1, 2, 2, 0, 0, 1, 1};
    chk_log(0, "rr", ed, eg);

    // backpressure
    clr_log(0);
    for (int k = 0; k < 4; k++) begin
      rpat[0].push_back(1); rpat[0].push_back(0);
      rpat[0].push_back(0); rpat[0].push_back(1);
    end
    push_frame(0, 3, 'h31, 4);
    run_until_idle(0, 2000);
    ed = '{'h31, 'h32, 'h33, 'h34}; eg = '{3, 3, 3, 3};
    chk_log(0, "backpressure", ed, eg);

    // reset with the 2nd of 5 bytes held in the output register
    clr_log(0);
    push_frame(0, 1, 'h51, 5);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(m_owner[0] == 1 && m_sent[0] == 2) && n < 40);
    chk("reach 2nd byte before reset", m_sent[0], 2);
    rst_next[0] = 1'b1;
    rpat[0].push_back(1);
    cycle();
    chk("req_ready under reset", s_rr[0], 0);
    rst_next[0] = 1'b0;
    rq[0][1].delete();
    cycle();
    chk("post reset tx_valid", s_txv[0], 0);
    chk("post reset busy", s_bsy[0], 0);
    chk("post reset req_ready", s_rr[0], 0);
    push_frame(0, 2, 'h61, 2);
    run_until_idle(0, 2000);
    ed = '{'h51, 'h61, 'h62}; eg = '{1, 2, 2};
    chk_log(0, "reset", ed, eg);

    // MAX_BYTES=4 release and re-arbitration
    clr_log(1);
    push_frame(1, 3, 'hA1, 6);
    cycle();
    push_frame(1, 0, 'hB1, 2);
    run_until_idle(1, 200);
    ed = '{'hA1, 'hA2, 'hA3, 'hA4, 'hB1, 'hB2, 'hA5, 'hA6};
    eg = '{3, 3, 3, 3, 0, 0, 3, 3};
    chk_log(1, "maxbytes", ed, eg);

    // GAP_CYCLES=0 back to back
    clr_log(1);
    push_frame(1, 0, 'hC1, 2);
    push_frame(1, 1, 'hD1, 2);
    run_until_idle(1, 200);
    ed = '{'hC1, 'hC2, 'hD1, 'hD2}; eg = '{0, 0, 1, 1};
    chk_log(1, "nogap", ed, eg);
    if (lg_c[1].size() > 1) chk("nogap regrant delay", gchg[1] - lg_c[1][1], 2);

    // randomized traffic on both lanes
    clr_log(0); clr_log(1);
    for (int l = 0; l < 2; l++) begin
      vprob[l] = $urandom_range(100, 40);
      rprob[l] = $urandom_range(100, 60);
      for (int f = 0; f < ((l == 0) ? 10 : 40); f++) begin
        len = $urandom_range((l == 0) ? 5 : 9, 1);
        push_frame(l, $urandom_range(NR - 1), $urandom_range(255), len);
        pushed[l] += len;
      end
    end
    n = 0;
    while (!(lane_idle(0) && lane_idle(1)) && n < 30000) begin
      cycle();
      n++;
    end
    chk("random traffic completes", (lane_idle(0) && lane_idle(1)) ? 1 : 0, 1);
    chk("L0 random byte total", lg_d[0].size(), pushed[0]);
    chk("L1 random byte total", lg_d[1].size(), pushed[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port between NUM_REQ byte-stream requesters, such as a command responder, a debug echo and status reporters.
- Uses round-robin arbitration at frame granularity. A grant is locked until the requester's last byte, or until MAX_BYTES bytes have been sent, whichever comes first.
- Inserts GAP_CYCLES of idle time between frames so the far-end receiver can resynchronise.
- Sits between the requester logic and the UART transmitter. Uses the same valid/ready byte handshake as the receiver side of the UART.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- MAX_BYTES, 64: forced grant release after this many bytes in one grant, range 1..255.
- GAP_CYCLES, 1250: idle clocks inserted between frames (one bit time at 9600 baud on 12 MHz); 0 means no gap. Counter is 16 bits.
- ID_W, $clog2(NUM_REQ): width of grant_id.

Ports:
- clock_12MHz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a frame; qualified by req_valid.
- req_ready  out  NUM_REQ  byte accepted from requester i when req_valid[i] && req_ready[i].
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- grant_id  out  ID_W  currently or most recently granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): takes effect at the clock edge where reset=1.
  - State=IDLE, rr_ptr=0, tx_valid=0, tx_data=0, grant_id=0, byte_cnt=0, gap_cnt=0.
  - req_ready is all zeros while reset is asserted.
  - Reset mid-frame drops the frame. Any byte held in the output register is discarded and is not transmitted. Requesters must restart the frame.
- Output register:
  - One-entry register tx_data/tx_valid. No combinational path from req_* to tx_*.
  - The register is "open" when !tx_valid || tx_ready.
- State machine (one-hot or binary; implementer's choice):
  - IDLE: if req_valid is non-zero, select the first asserted index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - Then grant_id<=sel, byte_cnt<=0, go to SEND.
    - No bytes are accepted in IDLE.
  - SEND:
    - req_ready[grant_id] = open; all other req_ready bits = 0.
    - On a handshake: tx_data<=byte, tx_valid<=1, byte_cnt<=byte_cnt+1.
    - If req_last is set, or byte_cnt==MAX_BYTES-1, go to DRAIN.
    - If tx_ready drains the register with no new handshake, tx_valid<=0.
  - DRAIN:
    - req_ready=0.
    - When tx_valid && tx_ready: tx_valid<=0, rr_ptr<=(grant_id+1) mod NUM_REQ.
    - If GAP_CYCLES==0 go to IDLE; otherwise gap_cnt<=GAP_CYCLES-1 and go to GAP.
    - If tx_valid is already 0 on entry, apply the same action immediately.
  - GAP: count gap_cnt down to 0, then go to IDLE. req_ready=0, tx_valid=0.
- Latency:
  - req_valid rising in IDLE at edge t gives SEND and req_ready at t+1.
  - A first-byte handshake at t+1 gives tx_valid=1 from t+2.
  - Throughput is 1 byte/clock while tx_ready stays high.
- Boundaries:
  - A granted requester that drops req_valid mid-frame keeps the grant; the arbiter stalls with no timeout.
  - Release on MAX_BYTES is not a frame end. The requester re-arbitrates and continues on its next grant.
  - req_last on byte number MAX_BYTES is treated as a single release.
  - Requests arriving during SEND/DRAIN/GAP wait. A non-granted req_valid never sees req_ready.
  - A single active requester is re-granted after each GAP; there is no starvation under RR.
  - grant_id is stable from the grant until the next grant.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, SEND, DRAIN, GAP);
  - CLKS_PER_BIT=1250, the default gap;
  - the byte typedef (8 bits).
- One sub-module, rr_select: combinational round-robin priority pick.
  - Inputs: request vector and pointer. Outputs: index and found flag.
  - Reusable by later arbiters.

Test Plan:
- Single frame: after reset, req0 sends 0x41,0x42,0x43 (last on 0x43) with tx_ready=1 → tx_data 0x41,0x42,0x43 on consecutive cycles starting 2 clocks after req_valid; busy held; 1250 idle cycles follow, then IDLE.
- Round robin: req1 and req2 each have a 2-byte frame pending from the same cycle → req1 frame, then the gap, then req2 frame; grant_id goes 1 then 2. Next simultaneous request on req0 and req1 grants req0 first (rr_ptr=3 wraps to 0).
- Backpressure: tx_ready toggles 1,0,0,1 during a 4-byte frame → no byte lost or duplicated; req_ready follows the open rule; tx_data holds while tx_ready=0.
- MAX_BYTES=4 (override): req3 sends 6 bytes with no last until byte 6, req0 also pending → 4 bytes from req3, then gap, then req0 frame, then the remaining 2 bytes from req3.
- Reset mid-frame: assert reset after the 2nd of 5 bytes with tx_valid=1 → the next cycle has tx_valid=0, busy=0, req_ready=0; after deassertion a new request on req2 is granted normally.
- GAP_CYCLES=0 (override): back-to-back frames from req0 then req1 → req1 is granted in the cycle after the final req0 byte drains.
